seq_accum_8b: RTL and testbench
===============================

// Module: seq_accum_8b
//
// PURPOSE
//   Sequential 8-bit accumulator. Each clock cycle the current input is added
//   to an internal running-sum register. The register value is presented
//   directly on the output.
//   Intended as a small datapath building block, e.g. a running-sum or
//   checksum stage. It needs no handshake and no flow control.
//
// PARAMETERS
//   WIDTH   8   Data width of in_, out and the accumulator register.
//               This spec and its tests assume 8.
//
// PORTS
//   clk     input   1      Clock; rising-edge triggered.
//   reset   input   1      Asynchronous, active-high reset.
//   in_     input   WIDTH  Addend sampled at each rising clk edge.
//   out     output  WIDTH  Current accumulator value, driven straight from the register.
//
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high.
//   - State: one WIDTH-bit register, acc. out = acc at all times.
//     There is no combinational path from in_ to out.
//   - Reset:
//       - When reset is asserted, acc is forced to 0 immediately, without
//         waiting for a clk edge, and out reads 0 in that same cycle.
//       - acc stays 0 for as long as reset is high.
//       - in_ is ignored while reset is high.
//   - Normal operation (reset low): at each rising clk edge, acc <= acc + in_.
//   - Latency: in_ applied in cycle N is visible in out during cycle N+1.
//   - Arithmetic:
//       - Unsigned modulo-2^WIDTH addition. The carry-out is discarded.
//       - There is no saturation and no overflow flag.
//       - Example of wrap-around: 0xFF + 0x01 -> 0x00.
//   - Release of reset: the first rising edge with reset low adds that
//     cycle's in_ to 0.
//   - Reset mid-operation: any accumulated value is lost. Accumulation
//     restarts from 0 once reset deasserts.
//   - in_ = 0 holds the current value.
//   - X on in_ while reset is high must not disturb acc.
//
// STRUCTURE
//   - Shared package: the WIDTH constant (default 8) and an acc_t typedef
//     (logic [WIDTH-1:0]).
//   - Optional sub-module: seq_accum_adder, a pure combinational WIDTH-bit
//     adder with no carry-out. It feeds a single always_ff register that has
//     an asynchronous clear.
//   - Everything else is flat. There is no FSM.
//
// TESTING  (inputs applied just after a rising edge; out checked just before the next edge)
//   1) Small values after reset. in_ = 00,01,02,04,04,00 ->
//      out = 00,00,01,03,07,0B.
//   2) Large values. in_ = 00,10,20,40,40,00 ->
//      out = 00,00,10,30,70,B0.
//   3) Overflow. in_ = 00,F0,0F,01,00 ->
//      out = 00,00,F0,FF,00 (wraps to 0).
//   4) Directed mid-stream reset.
//      - in_ = 00,01,02 gives out = 00,00,01.
//      - Then reset=1 for 3 cycles (in_=00): out = 00 in every reset cycle,
//        including the first, because the reset is asynchronous.
//      - Then in_ = 01,02,04,04,00 gives out = 00,01,03,07,0B.
//   5) Random input. 20 cycles of random in_ with reset low.
//      out must equal a reference model: sum of all prior in_ mod 256.
//   6) Random reset. 20 cycles with random reset and random in_.
//      The model clears to 0 in any cycle where reset=1 and otherwise
//      accumulates mod 256. Compare out every cycle.

Source files
------------

// File: rtl/seq_accum_8b_pkg.sv
// Shared width constant and accumulator data type for the running-sum block.
package seq_accum_8b_pkg;

    localparam int WIDTH = 8;

    typedef logic [WIDTH-1:0] acc_t;

endpackage

// File: rtl/seq_accum_adder.sv
// Pure combinational modulo-2^WIDTH adder; the carry-out is dropped by design.
module seq_accum_adder
    import seq_accum_8b_pkg::*;
(
    input  acc_t a,
    input  acc_t b,
    output acc_t sum
);

    assign sum = a + b;

endmodule

// File: rtl/seq_accum_8b.sv
// Running-sum accumulator: acc <= acc + in_ every clock, async clear, out = acc.
module seq_accum_8b
    import seq_accum_8b_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_,
    output logic [7:0] out
);

    acc_t acc;
    acc_t acc_next;

    seq_accum_adder u_adder (
        .a   (acc),
        .b   (in_),
        .sum (acc_next)
    );

    // Async clear keeps acc at 0 regardless of in_ (including X) while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign out = acc;

endmodule

// File: tb/tb_seq_accum_8b.sv
// Self-checking bench for seq_accum_8b using an expected-value queue.
module tb_seq_accum_8b;

    logic       clk;
    logic       reset;
    logic [7:0] in_;
    logic [7:0] out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];

    seq_accum_8b dut (
        .clk   (clk),
        .reset (reset),
        .in_   (in_),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle just after the rising edge, queue its expected out, wait until before the next edge.
    task automatic drive(input logic r, input logic [7:0] d, input logic [7:0] e);
        @(posedge clk);
        #1;
        reset = r;
        in_   = d;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset = 1'b1;
        in_   = 8'h00;
        #1;
        n_checks++;
        if (out !== 8'h00) $display("FAIL reset_before_clk got=%h exp=%h", out, 8'h00);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h00, 8'h00);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (out !== e) $display("FAIL reset_hold[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
    endtask

    task automatic test_small();
        logic [7:0] tin [6] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 8'h00};
        logic [7:0] texp[6] = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h07, 8'h0B};
        logic [7:0] e;
        drive(1'b1, 8'h00, 8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL small_pre_reset got=%h exp=%h", out, e);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tin[i], texp[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL small[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
    endtask

    task automatic test_large();
        logic [7:0] tin [6] = '{8'h00, 8'h10, 8'h20, 8'h40, 8'h40, 8'h00};
        logic [7:0] texp[6] = '{8'h00, 8'h00, 8'h10, 8'h30, 8'h70, 8'hB0};
        logic [7:0] e;
        drive(1'b1, 8'h00, 8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL large_pre_reset got=%h exp=%h", out, e);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tin[i], texp[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL large[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] tin [5] = '{8'h00, 8'hF0, 8'h0F, 8'h01, 8'h00};
        logic [7:0] texp[5] = '{8'h00, 8'h00, 8'hF0, 8'hFF, 8'h00};
        logic [7:0] e;
        drive(1'b1, 8'h00, 8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL ovf_pre_reset got=%h exp=%h", out, e);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, tin[i], texp[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL overflow[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic       tr  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] tin [12] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00,
                                 8'h01, 8'h02, 8'h04, 8'h04, 8'h00};
        logic [7:0] texp[12] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h01, 8'h03, 8'h07, 8'h0B};
        logic [7:0] e;
        for (int i = 0; i < 12; i++) begin
            drive(tr[i], tin[i], texp[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL mid_reset[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_x();
        logic [7:0] e;
        drive(1'b0, 8'h33, 8'h0B);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL x_pre got=%h exp=%h", out, e);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hxx, 8'h00);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL x_in_reset[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
        drive(1'b0, 8'h05, 8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL x_release got=%h exp=%h", out, e);
        else n_pass++;
        drive(1'b0, 8'h00, 8'h05);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL x_after got=%h exp=%h", out, e);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] m;
        logic [7:0] d;
        logic [7:0] e;
        drive(1'b1, 8'h00, 8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL rand_pre_reset got=%h exp=%h", out, e);
        else n_pass++;
        m = 8'h00;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            drive(1'b0, d, m);
            m = 8'(m + d);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL random[%0d] got=%h exp=%h", i, out, e);
            else n_pass++;
        end
    endtask

    task automatic test_random_reset();
        logic [7:0] m;
        logic [7:0] d;
        logic [7:0] e;
        logic       r;
        drive(1'b1, 8'h00, 8'h00);
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) $display("FAIL rrst_pre_reset got=%h exp=%h", out, e);
        else n_pass++;
        m = 8'h00;
        for (int i = 0; i < 20; i++) begin
            r = ($urandom_range(0, 3) == 0);
            d = r ? 8'hxx : 8'($urandom_range(0, 255));
            if (r) m = 8'h00;
            drive(r, d, m);
            if (!r) m = 8'(m + d);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) $display("FAIL random_reset[%0d] got=%h exp=%h rst=%b", i, out, e, r);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_   = 8'h00;
        test_reset();
        test_small();
        test_large();
        test_overflow();
        test_mid_reset();
        test_reset_x();
        test_random();
        test_random_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
